// File: rtl/multi_channel_debounce_sync.sv
// multi_channel_debounce_sync
//   WIDTH independent channels, each made of:
//   - a SYNC_STAGES-deep metastability chain,
//   - a stable-count debouncer that only moves sync_out after DEBOUNCE_CYCLES
//     consecutive mismatching cycles,
//   - registered rise/fall pulses, plus any_change (OR of all pulses).
// Optional feature macro: GLITCH_COUNT_EN adds glitch_clr / glitch_count and a
// saturating 8-bit rejected-glitch counter per channel.
module multi_channel_debounce_sync #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   async_in,
    output logic [WIDTH-1:0]   sync_out,
    output logic [WIDTH-1:0]   rise_pulse,
    output logic [WIDTH-1:0]   fall_pulse,
    output logic               any_change
`ifdef GLITCH_COUNT_EN
    ,
    input  logic               glitch_clr,
    output logic [8*WIDTH-1:0] glitch_count
`endif
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity checks at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("multi_channel_debounce_sync: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_channel_debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("multi_channel_debounce_sync: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    logic [WIDTH-1:0] sync_out_q, sync_out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_change_q;
    logic [WIDTH-1:0] glitch_ev;

    // Synchroniser chain: stage 0 samples the raw input, later stages shift.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            // First flop: captures the asynchronous input.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q[0] <= RESET_VALUE;
                else     sync_q[0] <= async_in;
            end
        end else begin : g_next
            // Subsequent flops: resolve metastability.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q[gi] <= RESET_VALUE;
                else     sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Per-channel debounce counters.
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Next-state: clear on match, update output on the last mismatching cycle, else count.
        always_comb begin
            cnt_d          = '0;
            sync_out_d[gi] = sync_out_q[gi];
            rise_d[gi]     = 1'b0;
            fall_d[gi]     = 1'b0;
            if (synced[gi] != sync_out_q[gi]) begin
                if (cnt_q == CNT_LAST) begin
                    sync_out_d[gi] = synced[gi];
                    rise_d[gi]     = synced[gi];
                    fall_d[gi]     = ~synced[gi];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        // A mismatch run that ended by returning to the current level is a rejected glitch.
        assign glitch_ev[gi] = (synced[gi] == sync_out_q[gi]) && (cnt_q != '0);
    end

    // Output level and single-cycle pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_out_q   <= RESET_VALUE;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
        end else begin
            sync_out_q   <= sync_out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= |(rise_d | fall_d);
        end
    end

    assign sync_out   = sync_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_change_q;

`ifdef GLITCH_COUNT_EN
    for (gi = 0; gi < WIDTH; gi++) begin : g_glitch
        logic [7:0] gcnt_q, gcnt_d;

        // Saturating increment; a clear takes priority over a coincident glitch.
        always_comb begin
            gcnt_d = gcnt_q;
            if (glitch_clr) begin
                gcnt_d = 8'h00;
            end else if (glitch_ev[gi] && (gcnt_q != 8'hFF)) begin
                gcnt_d = gcnt_q + 8'd1;
            end
        end

        // Glitch counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) gcnt_q <= 8'h00;
            else     gcnt_q <= gcnt_d;
        end

        assign glitch_count[8*gi +: 8] = gcnt_q;
    end
`else
    // Without the counters the glitch detector has no consumer.
    logic unused_glitch;
    assign unused_glitch = ^glitch_ev;
`endif

endmodule

// File: tb/tb_multi_channel_debounce_sync.sv
// Directed bench for multi_channel_debounce_sync (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Inputs change 1 ns after a rising edge ("edge 0");
// outputs are sampled 1 ns after the edge under test.
module tb_multi_channel_debounce_sync;

    logic        clk;
    logic        rst;
    logic [3:0]  async_in;
    logic [3:0]  sync_out;
    logic [3:0]  rise_pulse;
    logic [3:0]  fall_pulse;
    logic        any_change;
`ifdef GLITCH_COUNT_EN
    logic        glitch_clr;
    logic [31:0] glitch_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    multi_channel_debounce_sync #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (4'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .async_in     (async_in),
        .sync_out     (sync_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .any_change   (any_change)
`ifdef GLITCH_COUNT_EN
        ,
        .glitch_clr   (glitch_clr),
        .glitch_count (glitch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) begin
            $display("[%0t] vec %0d %s obs=%h ok", $time, vec_cnt, tag, obs);
        end else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        async_in = 4'h0;
`ifdef GLITCH_COUNT_EN
        glitch_clr = 1'b0;
`endif

        // Reset state
        edges(3);
        chk("rst_sync_out", 32'(sync_out), 32'h0);
        chk("rst_rise", 32'(rise_pulse), 32'h0);
        chk("rst_fall", 32'(fall_pulse), 32'h0);
        chk("rst_any", 32'(any_change), 32'h0);
`ifdef GLITCH_COUNT_EN
        chk("rst_glitch", glitch_count, 32'h0);
`endif

        // Reset held while inputs are high: nothing moves
        async_in = 4'hF;
        edges(4);
        chk("rsthold_sync_out", 32'(sync_out), 32'h0);
        chk("rsthold_rise", 32'(rise_pulse), 32'h0);

        // Release with inputs at the reset level: never any pulse
        async_in = 4'h0;
        edges(3);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            chk("idle_sync_out", 32'(sync_out), 32'h0);
            chk("idle_any", 32'(any_change), 32'h0);
        end

        // ch0 clean rising step: update at the 6th edge after the change
        async_in = 4'h1;
        edges(5);
        chk("ch0_e5_sync_out", 32'(sync_out), 32'h0);
        chk("ch0_e5_rise", 32'(rise_pulse), 32'h0);
        edges(1);
        chk("ch0_e6_sync_out", 32'(sync_out), 32'h1);
        chk("ch0_e6_rise", 32'(rise_pulse), 32'h1);
        chk("ch0_e6_fall", 32'(fall_pulse), 32'h0);
        chk("ch0_e6_any", 32'(any_change), 32'h1);
        edges(1);
        chk("ch0_e7_sync_out", 32'(sync_out), 32'h1);
        chk("ch0_e7_rise", 32'(rise_pulse), 32'h0);
        chk("ch0_e7_any", 32'(any_change), 32'h0);

        // ch1 high for 3 cycles: rejected glitch
        async_in = 4'h3;
        edges(3);
        async_in = 4'h1;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("ch1_glitch_sync_out", 32'(sync_out), 32'h1);
            chk("ch1_glitch_rise", 32'(rise_pulse), 32'h0);
            chk("ch1_glitch_any", 32'(any_change), 32'h0);
        end
`ifdef GLITCH_COUNT_EN
        chk("ch1_glitch_count", glitch_count, 32'h0000_0100);
`endif

        // ch2+ch3 step together, then fall together 10 cycles later
        async_in = 4'hD;
        edges(5);
        chk("ch23_rise_e5_sync_out", 32'(sync_out), 32'h1);
        chk("ch23_rise_e5_rise", 32'(rise_pulse), 32'h0);
        edges(1);
        chk("ch23_rise_e6_sync_out", 32'(sync_out), 32'hD);
        chk("ch23_rise_e6_rise", 32'(rise_pulse), 32'hC);
        chk("ch23_rise_e6_fall", 32'(fall_pulse), 32'h0);
        chk("ch23_rise_e6_any", 32'(any_change), 32'h1);
        edges(1);
        chk("ch23_rise_e7_rise", 32'(rise_pulse), 32'h0);
        chk("ch23_rise_e7_any", 32'(any_change), 32'h0);
        edges(3);
        async_in = 4'h1;
        edges(5);
        chk("ch23_fall_e5_sync_out", 32'(sync_out), 32'hD);
        chk("ch23_fall_e5_fall", 32'(fall_pulse), 32'h0);
        edges(1);
        chk("ch23_fall_e6_sync_out", 32'(sync_out), 32'h1);
        chk("ch23_fall_e6_fall", 32'(fall_pulse), 32'hC);
        chk("ch23_fall_e6_rise", 32'(rise_pulse), 32'h0);
        chk("ch23_fall_e6_any", 32'(any_change), 32'h1);
        edges(1);
        chk("ch23_fall_e7_fall", 32'(fall_pulse), 32'h0);
        chk("ch23_fall_e7_any", 32'(any_change), 32'h0);

        // Reset in the middle of a ch1 count: outputs drop at once
        async_in = 4'h3;
        edges(4);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sync_out", 32'(sync_out), 32'h0);
        chk("midrst_rise", 32'(rise_pulse), 32'h0);
        chk("midrst_any", 32'(any_change), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edges(5);
        chk("postrst_e5_sync_out", 32'(sync_out), 32'h0);
        chk("postrst_e5_any", 32'(any_change), 32'h0);
        edges(1);
        chk("postrst_e6_sync_out", 32'(sync_out), 32'h3);
        chk("postrst_e6_rise", 32'(rise_pulse), 32'h3);
        chk("postrst_e6_any", 32'(any_change), 32'h1);
        edges(1);
        chk("postrst_e7_rise", 32'(rise_pulse), 32'h0);

`ifdef GLITCH_COUNT_EN
        // 300 one-cycle glitches on ch3 saturate its counter
        chk("postrst_glitch", glitch_count, 32'h0);
        for (int i = 0; i < 300; i++) begin
            async_in = 4'hB;
            edges(1);
            async_in = 4'h3;
            edges(4);
        end
        chk("sat_sync_out", 32'(sync_out), 32'h3);
        chk("sat_glitch_count", glitch_count, 32'hFF00_0000);
        glitch_clr = 1'b1;
        edges(1);
        glitch_clr = 1'b0;
        chk("clr_glitch_count", glitch_count, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
